alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline register that captures decoded operands and ALU control each cycle.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages and drives the A, B and op inputs of the ALU, including its logical sub-unit.
- Detects load-use hazards and supports stall (hold) and flush (bubble) from the hazard controller.

Parameters:
- N, 32, datapath width.
- RW, 5, register address width.
- CW, 4, ALU control width; the low 2 bits are the logical-unit op.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs_addr, id_rt_addr  in  RW  source register numbers.
- id_rs_data, id_rt_data  in  N  register-file read data.
- id_imm  in  N  extended immediate.
- id_use_imm  in  1  B operand source: 1 = imm, 0 = rt.
- id_alu_ctrl  in  CW  ALU operation.
- id_dest_addr  in  RW  destination register.
- id_reg_write, id_mem_read  in  1  write-back enable; instruction is a load.
- stall  in  1  hold stage contents.
- flush  in  1  replace the captured instruction with a bubble.
- mem_fwd_we, mem_fwd_addr, mem_fwd_data  in  1/RW/N  EX/MEM result.
- wb_fwd_we, wb_fwd_addr, wb_fwd_data  in  1/RW/N  MEM/WB result.
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control.
- ex_dest_addr  out  RW  registered destination.
- ex_alu_ctrl  out  CW  registered ALU control.
- ex_A, ex_B  out  N  forwarded ALU operands (combinational from registered state).
- ex_store_data  out  N  forwarded rt value, independent of use_imm.
- load_use_hazard  out  1  combinational stall request to the hazard controller.

Behaviour:
- Reset: the synchronous reset clears all registers to 0, so every registered output is 0 after the clock edge and ex_valid=0. Reset beats flush, and flush beats stall.
- Capture, with stall=0 and flush=0: on the clock edge, all id_* values are latched. Latency is one cycle from ID to the ex_* outputs.
- flush=1: on the edge, valid, reg_write and mem_read become 0. Data registers may take any value.
- stall=1 and flush=0: all registers hold.
  - Exception: if wb_fwd_we=1, wb_fwd_addr!=0 and wb_fwd_addr equals the held rs_addr or rt_addr, the matching held data register loads wb_fwd_data.
  - This prevents a producer leaving WB during a stall from being lost.
- Forwarding, evaluated per operand (rs and rt independently):
  - If mem_fwd_we=1, addr!=0 and mem_fwd_addr equals the operand address, select mem_fwd_data.
  - Else, if the same condition holds for WB, select wb_fwd_data.
  - Else, select the registered data.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded; the registered value is used.
- Operand outputs:
  - ex_A = forwarded rs.
  - ex_B = registered use_imm ? registered imm : forwarded rt.
  - ex_store_data = forwarded rt.
- Outputs while ex_valid=0: operand outputs are don't-care. ex_reg_write=0 and ex_mem_read=0 are guaranteed.
- load_use_hazard = ex_valid & ex_mem_read & (ex_dest_addr!=0) & id_valid & (ex_dest_addr==id_rs_addr | (!id_use_imm & ex_dest_addr==id_rt_addr)).
  - The controller responds by asserting stall on the IF/ID stages and flush on this stage.
- Simultaneous events:
  - stall and flush together produce a bubble.
  - A WB write during a non-stalled capture is not merged. The register file's write-before-read provides that value.

Decomposition:
- Shared package cpu_pkg holds:
  - Width constants N_DATA and N_REG.
  - ALU control encodings: logical AND=00, OR=01, XOR=10, NOR=11 in the low bits, plus ADD/SUB/SLT/shift codes.
  - Register-0 constant.
- Sub-module fwd_mux (N, RW): takes an operand address and registered data plus both forwarding ports, returns the selected data. It is instantiated twice, for rs and rt.

Test Plan:
- Reset held 2 cycles with id_valid=1 and all inputs 1s -> all registered outputs 0, load_use_hazard=0.
- Capture rs=3 (data 0x5), rt=4 (data 0xA), ctrl=OR, with no forward matches -> next cycle ex_A=0x5, ex_B=0xA, ex_alu_ctrl=OR, ex_valid=1.
- rs=7 registered data 0x1, mem fwd (7, 0xAAAA), wb fwd (7, 0xBBBB) -> ex_A=0xAAAA. Remove the mem match -> ex_A=0xBBBB. With rs=0 and both ports addressing 0 -> ex_A=0.
- Stall 3 cycles while wb writes r4=0x1234 in the second stall cycle (held rt=4) -> after stall release with no forwards, ex_B=0x1234. Other fields unchanged.
- EX holds a load with dest 9; ID issues rs=9 -> load_use_hazard=1. ID instead uses rt=9 with use_imm=1 -> 0. dest 0 -> 0.
- stall=1 and flush=1 together -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU control encodings, register zero.
package cpu_pkg;

  localparam int N_DATA = 32;
  localparam int N_REG  = 5;
  localparam int N_CTRL = 4;

  localparam logic [N_REG-1:0] REG_ZERO = '0;

  // Low two bits select the logical sub-unit operation.
  typedef enum logic [N_CTRL-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_NOR = 4'b0011,
    ALU_ADD = 4'b0100,
    ALU_SUB = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010
  } alu_ctrl_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM result beats MEM/WB result beats
// the registered value. Register zero is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int N  = N_DATA,
  parameter int RW = N_REG
) (
  input  logic [RW-1:0] op_addr_i,
  input  logic [N-1:0]  op_data_i,
  input  logic          mem_we_i,
  input  logic [RW-1:0] mem_addr_i,
  input  logic [N-1:0]  mem_data_i,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_addr_i,
  input  logic [N-1:0]  wb_data_i,
  output logic [N-1:0]  data_o
);

  logic nonzero;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (op_addr_i != '0);
  assign mem_hit = mem_we_i && nonzero && (mem_addr_i == op_addr_i);
  assign wb_hit  = wb_we_i  && nonzero && (wb_addr_i  == op_addr_i);

  // Priority select of the freshest producer.
  always_comb begin
    data_o = op_data_i;
    if (mem_hit)     data_o = mem_data_i;
    else if (wb_hit) data_o = wb_data_i;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding, stall/flush handling
// and load-use hazard detection.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int N  = N_DATA,
  parameter int RW = N_REG,
  parameter int CW = N_CTRL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [N-1:0]  id_rs_data,
  input  logic [N-1:0]  id_rt_data,
  input  logic [N-1:0]  id_imm,
  input  logic          id_use_imm,
  input  logic [CW-1:0] id_alu_ctrl,
  input  logic [RW-1:0] id_dest_addr,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_fwd_we,
  input  logic [RW-1:0] mem_fwd_addr,
  input  logic [N-1:0]  mem_fwd_data,
  input  logic          wb_fwd_we,
  input  logic [RW-1:0] wb_fwd_addr,
  input  logic [N-1:0]  wb_fwd_data,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic [RW-1:0] ex_dest_addr,
  output logic [CW-1:0] ex_alu_ctrl,
  output logic [N-1:0]  ex_A,
  output logic [N-1:0]  ex_B,
  output logic [N-1:0]  ex_store_data,
  output logic          load_use_hazard
);

  logic          valid_q,     valid_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q,  mem_read_d;
  logic [RW-1:0] dest_q,      dest_d;
  logic [CW-1:0] ctrl_q,      ctrl_d;
  logic [RW-1:0] rs_addr_q,   rs_addr_d;
  logic [RW-1:0] rt_addr_q,   rt_addr_d;
  logic [N-1:0]  rs_data_q,   rs_data_d;
  logic [N-1:0]  rt_data_q,   rt_data_d;
  logic [N-1:0]  imm_q,       imm_d;
  logic          use_imm_q,   use_imm_d;

  logic [N-1:0]  rs_fwd;
  logic [N-1:0]  rt_fwd;

  // Next-state: flush makes a bubble, capture when free, otherwise hold
  // while absorbing a WB result aimed at a held source register.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    dest_d      = dest_q;
    ctrl_d      = ctrl_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (!stall) begin
      valid_d     = id_valid;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      dest_d      = id_dest_addr;
      ctrl_d      = id_alu_ctrl;
      rs_addr_d   = id_rs_addr;
      rt_addr_d   = id_rt_addr;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      use_imm_d   = id_use_imm;
    end else if (wb_fwd_we && (wb_fwd_addr != REG_ZERO)) begin
      // The WB producer retires during the stall; keep its value.
      if (wb_fwd_addr == rs_addr_q) rs_data_d = wb_fwd_data;
      if (wb_fwd_addr == rt_addr_q) rt_data_d = wb_fwd_data;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      dest_q      <= '0;
      ctrl_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      dest_q      <= dest_d;
      ctrl_q      <= ctrl_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
    end
  end

  fwd_mux #(.N(N), .RW(RW)) u_fwd_rs (
    .op_addr_i  (rs_addr_q),
    .op_data_i  (rs_data_q),
    .mem_we_i   (mem_fwd_we),
    .mem_addr_i (mem_fwd_addr),
    .mem_data_i (mem_fwd_data),
    .wb_we_i    (wb_fwd_we),
    .wb_addr_i  (wb_fwd_addr),
    .wb_data_i  (wb_fwd_data),
    .data_o     (rs_fwd)
  );

  fwd_mux #(.N(N), .RW(RW)) u_fwd_rt (
    .op_addr_i  (rt_addr_q),
    .op_data_i  (rt_data_q),
    .mem_we_i   (mem_fwd_we),
    .mem_addr_i (mem_fwd_addr),
    .mem_data_i (mem_fwd_data),
    .wb_we_i    (wb_fwd_we),
    .wb_addr_i  (wb_fwd_addr),
    .wb_data_i  (wb_fwd_data),
    .data_o     (rt_fwd)
  );

  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_dest_addr  = dest_q;
  assign ex_alu_ctrl   = ctrl_q;
  assign ex_A          = rs_fwd;
  assign ex_B          = use_imm_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;

  // A load in EX feeding an ID source that actually reads the register.
  assign load_use_hazard = valid_q && mem_read_q && (dest_q != REG_ZERO) && id_valid &&
                           ((dest_q == id_rs_addr) || (!id_use_imm && (dest_q == id_rt_addr)));

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dest_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read;
  logic [3:0]  id_alu_ctrl;
  logic        stall, flush;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_dest_addr;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic        load_use_hazard;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_dest_addr(id_dest_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .flush(flush),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dest_addr(ex_dest_addr), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; id_valid = 1'b0;
    id_rs_addr = '0; id_rt_addr = '0; id_dest_addr = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_use_imm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_alu_ctrl = '0; stall = 1'b0; flush = 1'b0;
    mem_fwd_we = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
    wb_fwd_we = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; id_valid = 1'b1;
    id_rs_addr = '1; id_rt_addr = '1; id_dest_addr = '1;
    id_rs_data = '1; id_rt_data = '1; id_imm = '1;
    id_use_imm = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1;
    id_alu_ctrl = '1; stall = 1'b1; flush = 1'b1;
    mem_fwd_we = 1'b1; mem_fwd_addr = '1; mem_fwd_data = '1;
    wb_fwd_we = 1'b1; wb_fwd_addr = '1; wb_fwd_data = '1;
    step(); step();
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", ex_valid); else passed++;
    total++; if (ex_reg_write !== 1'b0) $display("FAIL reset_reg_write got %0h exp 0", ex_reg_write); else passed++;
    total++; if (ex_mem_read !== 1'b0) $display("FAIL reset_mem_read got %0h exp 0", ex_mem_read); else passed++;
    total++; if (ex_dest_addr !== 5'd0) $display("FAIL reset_dest got %0h exp 0", ex_dest_addr); else passed++;
    total++; if (ex_alu_ctrl !== 4'd0) $display("FAIL reset_ctrl got %0h exp 0", ex_alu_ctrl); else passed++;
    total++; if (ex_A !== 32'd0) $display("FAIL reset_A got %0h exp 0", ex_A); else passed++;
    total++; if (ex_B !== 32'd0) $display("FAIL reset_B got %0h exp 0", ex_B); else passed++;
    total++; if (load_use_hazard !== 1'b0) $display("FAIL reset_hazard got %0h exp 0", load_use_hazard); else passed++;
    clear_inputs();
  endtask

  task automatic test_capture();
    id_valid = 1'b1; id_rs_addr = 5'd3; id_rs_data = 32'h5;
    id_rt_addr = 5'd4; id_rt_data = 32'hA; id_alu_ctrl = ALU_OR;
    id_dest_addr = 5'd2; id_reg_write = 1'b1; id_imm = 32'h77;
    step();
    total++; if (ex_A !== 32'h5) $display("FAIL cap_A got %0h exp 5", ex_A); else passed++;
    total++; if (ex_B !== 32'hA) $display("FAIL cap_B got %0h exp a", ex_B); else passed++;
    total++; if (ex_alu_ctrl !== ALU_OR) $display("FAIL cap_ctrl got %0h exp 1", ex_alu_ctrl); else passed++;
    total++; if (ex_valid !== 1'b1) $display("FAIL cap_valid got %0h exp 1", ex_valid); else passed++;
    total++; if (ex_dest_addr !== 5'd2) $display("FAIL cap_dest got %0h exp 2", ex_dest_addr); else passed++;
    total++; if (ex_reg_write !== 1'b1) $display("FAIL cap_reg_write got %0h exp 1", ex_reg_write); else passed++;
    id_use_imm = 1'b1; id_alu_ctrl = ALU_XOR;
    step();
    total++; if (ex_B !== 32'h77) $display("FAIL imm_B got %0h exp 77", ex_B); else passed++;
    total++; if (ex_store_data !== 32'hA) $display("FAIL imm_store got %0h exp a", ex_store_data); else passed++;
    total++; if (ex_alu_ctrl !== ALU_XOR) $display("FAIL imm_ctrl got %0h exp 2", ex_alu_ctrl); else passed++;
    id_use_imm = 1'b0;
  endtask

  task automatic test_forward();
    id_valid = 1'b1; id_rs_addr = 5'd7; id_rs_data = 32'h1;
    id_rt_addr = 5'd5; id_rt_data = 32'h2; id_use_imm = 1'b0;
    step();
    mem_fwd_we = 1'b1; mem_fwd_addr = 5'd7; mem_fwd_data = 32'hAAAA;
    wb_fwd_we = 1'b1; wb_fwd_addr = 5'd7; wb_fwd_data = 32'hBBBB;
    #1;
    total++; if (ex_A !== 32'hAAAA) $display("FAIL fwd_mem_prio got %0h exp aaaa", ex_A); else passed++;
    total++; if (ex_B !== 32'h2) $display("FAIL fwd_rt_untouched got %0h exp 2", ex_B); else passed++;
    mem_fwd_addr = 5'd8;
    #1;
    total++; if (ex_A !== 32'hBBBB) $display("FAIL fwd_wb got %0h exp bbbb", ex_A); else passed++;
    wb_fwd_addr = 5'd5; wb_fwd_data = 32'hCCCC;
    #1;
    total++; if (ex_A !== 32'h1) $display("FAIL fwd_none_A got %0h exp 1", ex_A); else passed++;
    total++; if (ex_store_data !== 32'hCCCC) $display("FAIL fwd_wb_rt got %0h exp cccc", ex_store_data); else passed++;
    mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
    id_rs_addr = 5'd0; id_rs_data = 32'h0;
    step();
    mem_fwd_we = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'hAAAA;
    wb_fwd_we = 1'b1; wb_fwd_addr = 5'd0; wb_fwd_data = 32'hBBBB;
    #1;
    total++; if (ex_A !== 32'h0) $display("FAIL fwd_r0 got %0h exp 0", ex_A); else passed++;
    mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
  endtask

  task automatic test_stall_wb();
    id_valid = 1'b1; id_rs_addr = 5'd3; id_rs_data = 32'h5;
    id_rt_addr = 5'd4; id_rt_data = 32'hA; id_alu_ctrl = ALU_OR;
    id_dest_addr = 5'd2; id_reg_write = 1'b1; id_use_imm = 1'b0;
    step();
    id_rs_addr = 5'd6; id_rs_data = 32'h66; id_rt_addr = 5'd8; id_rt_data = 32'h88;
    id_alu_ctrl = ALU_NOR; id_dest_addr = 5'd1; id_reg_write = 1'b0;
    stall = 1'b1;
    step();
    wb_fwd_we = 1'b1; wb_fwd_addr = 5'd4; wb_fwd_data = 32'h1234;
    step();
    wb_fwd_we = 1'b0;
    step();
    stall = 1'b0;
    #1;
    total++; if (ex_B !== 32'h1234) $display("FAIL stall_wb_B got %0h exp 1234", ex_B); else passed++;
    total++; if (ex_A !== 32'h5) $display("FAIL stall_A got %0h exp 5", ex_A); else passed++;
    total++; if (ex_alu_ctrl !== ALU_OR) $display("FAIL stall_ctrl got %0h exp 1", ex_alu_ctrl); else passed++;
    total++; if (ex_dest_addr !== 5'd2) $display("FAIL stall_dest got %0h exp 2", ex_dest_addr); else passed++;
    total++; if (ex_reg_write !== 1'b1) $display("FAIL stall_reg_write got %0h exp 1", ex_reg_write); else passed++;
    step();
    total++; if (ex_A !== 32'h66) $display("FAIL release_A got %0h exp 66", ex_A); else passed++;
    total++; if (ex_alu_ctrl !== ALU_NOR) $display("FAIL release_ctrl got %0h exp 3", ex_alu_ctrl); else passed++;
  endtask

  task automatic test_load_use();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_dest_addr = 5'd9;
    id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_use_imm = 1'b0;
    step();
    id_mem_read = 1'b0; id_rs_addr = 5'd9; id_rt_addr = 5'd1;
    #1;
    total++; if (load_use_hazard !== 1'b1) $display("FAIL lu_rs got %0h exp 1", load_use_hazard); else passed++;
    id_rs_addr = 5'd1; id_rt_addr = 5'd9; id_use_imm = 1'b1;
    #1;
    total++; if (load_use_hazard !== 1'b0) $display("FAIL lu_rt_imm got %0h exp 0", load_use_hazard); else passed++;
    id_use_imm = 1'b0;
    #1;
    total++; if (load_use_hazard !== 1'b1) $display("FAIL lu_rt got %0h exp 1", load_use_hazard); else passed++;
    id_valid = 1'b0;
    #1;
    total++; if (load_use_hazard !== 1'b0) $display("FAIL lu_id_invalid got %0h exp 0", load_use_hazard); else passed++;
    id_valid = 1'b1; id_mem_read = 1'b1; id_dest_addr = 5'd0;
    step();
    id_mem_read = 1'b0; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    #1;
    total++; if (load_use_hazard !== 1'b0) $display("FAIL lu_dest0 got %0h exp 0", load_use_hazard); else passed++;
  endtask

  task automatic test_stall_flush();
    id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_dest_addr = 5'd12;
    step();
    total++; if (ex_mem_read !== 1'b1) $display("FAIL sf_pre_mem_read got %0h exp 1", ex_mem_read); else passed++;
    stall = 1'b1; flush = 1'b1;
    step();
    total++; if (ex_valid !== 1'b0) $display("FAIL sf_valid got %0h exp 0", ex_valid); else passed++;
    total++; if (ex_reg_write !== 1'b0) $display("FAIL sf_reg_write got %0h exp 0", ex_reg_write); else passed++;
    total++; if (ex_mem_read !== 1'b0) $display("FAIL sf_mem_read got %0h exp 0", ex_mem_read); else passed++;
    stall = 1'b0; flush = 1'b0;
    step();
    total++; if (ex_valid !== 1'b1) $display("FAIL sf_recover got %0h exp 1", ex_valid); else passed++;
    flush = 1'b1;
    step();
    total++; if (ex_reg_write !== 1'b0) $display("FAIL flush_only got %0h exp 0", ex_reg_write); else passed++;
    flush = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_capture();
    test_forward();
    test_stall_wb();
    test_load_use();
    test_stall_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
